// File: rtl/cpu4_regfile_writer.sv
// cpu4_regfile_writer: write-port master for cpu4_regfile.
// Merges the ALU result path and a FIFO-buffered LSU result path onto the
// single register-file write port, one write per cycle. ALU normally wins;
// a FIFO head that has waited STARVE_LIMIT cycles forces priority.
// Optional build macro: CPU4_WB_X0_FILTER_EN (suppresses wen for writes to x0).
module cpu4_regfile_writer #(
   parameter int FIFO_DEPTH   = 4,
   parameter int STARVE_LIMIT = 3,
   localparam int AW = $clog2(FIFO_DEPTH),
   localparam int CW = $clog2(FIFO_DEPTH) + 1
) (
   input  logic          clk,
   input  logic          resetn,
   input  logic          alu_valid,
   output logic          alu_ready,
   input  logic [4:0]    alu_rdidx,
   input  logic [31:0]   alu_rddata,
   input  logic          lsu_valid,
   output logic          lsu_ready,
   input  logic [4:0]    lsu_rdidx,
   input  logic [31:0]   lsu_rddata,
   output logic          wen,
   output logic [4:0]    rdidx,
   output logic [31:0]   rddata,
   output logic [CW-1:0] fifo_count,
   output logic          busy
);

   logic [4:0]    mem_idx  [FIFO_DEPTH];
   logic [31:0]   mem_data [FIFO_DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [3:0]    wait_cnt;

   logic          fifo_empty;
   logic          starve;
   logic          push;
   logic          pop;
   logic          sel_valid;
   logic [4:0]    sel_idx;
   logic [31:0]   sel_data;
   logic          wr_en;

   // Arbitration and handshakes; a same-cycle push is never visible to pop
   // because occupancy is registered, so there is no flow-through.
   always_comb begin
      fifo_empty = (fifo_count == '0);
      starve     = (wait_cnt == 4'(STARVE_LIMIT)) && !fifo_empty;
      lsu_ready  = (fifo_count != CW'(FIFO_DEPTH));
      push       = lsu_valid && lsu_ready;
      alu_ready  = alu_valid && !starve;
      pop        = !fifo_empty && (starve || !alu_valid);
      sel_valid  = alu_ready || pop;
      sel_idx    = pop ? mem_idx[rd_ptr]  : alu_rdidx;
      sel_data   = pop ? mem_data[rd_ptr] : alu_rddata;
`ifdef CPU4_WB_X0_FILTER_EN
      wr_en      = sel_valid && (sel_idx != 5'd0);
`else
      wr_en      = sel_valid;
`endif
      busy       = !fifo_empty || wen;
   end

   // FIFO storage; contents need no reset since occupancy gates every read.
   always_ff @(posedge clk) begin
      if (push) begin
         mem_idx[wr_ptr]  <= lsu_rdidx;
         mem_data[wr_ptr] <= lsu_rddata;
      end
   end

   // FIFO pointers and occupancy; pointers wrap naturally at a power of two.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         fifo_count <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({push, pop})
            2'b10:   fifo_count <= fifo_count + 1'b1;
            2'b01:   fifo_count <= fifo_count - 1'b1;
            default: fifo_count <= fifo_count;
         endcase
      end
   end

   // Starvation counter: how long the current head has been passed over.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         wait_cnt <= '0;
      end else if (pop || fifo_empty) begin
         wait_cnt <= '0;
      end else if (wait_cnt != 4'(STARVE_LIMIT)) begin
         wait_cnt <= wait_cnt + 1'b1;
      end
   end

   // Registered write port; index/data hold their last value while wen is low.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         wen    <= 1'b0;
         rdidx  <= '0;
         rddata <= '0;
      end else begin
         wen <= wr_en;
         if (wr_en) begin
            rdidx  <= sel_idx;
            rddata <= sel_data;
         end
      end
   end

endmodule

// File: tb/tb_cpu4_regfile_writer.sv
// Scoreboard bench for cpu4_regfile_writer: directed stimulus pushes the
// hand-derived write order into a queue; a negedge monitor pops on each wen.
module tb_cpu4_regfile_writer;

   typedef struct packed {
      logic [4:0]  idx;
      logic [31:0] data;
   } wr_t;

   logic        clk = 1'b0;
   logic        resetn;
   logic        alu_valid, alu_ready;
   logic [4:0]  alu_rdidx;
   logic [31:0] alu_rddata;
   logic        lsu_valid, lsu_ready;
   logic [4:0]  lsu_rdidx;
   logic [31:0] lsu_rddata;
   logic        wen;
   logic [4:0]  rdidx;
   logic [31:0] rddata;
   logic [2:0]  fifo_count;
   logic        busy;

   int  checks = 0;
   int  errors = 0;
   wr_t exp_q[$];
   logic [31:0] rf [32];

   cpu4_regfile_writer #(.FIFO_DEPTH(4), .STARVE_LIMIT(3)) dut (
      .clk(clk), .resetn(resetn),
      .alu_valid(alu_valid), .alu_ready(alu_ready),
      .alu_rdidx(alu_rdidx), .alu_rddata(alu_rddata),
      .lsu_valid(lsu_valid), .lsu_ready(lsu_ready),
      .lsu_rdidx(lsu_rdidx), .lsu_rddata(lsu_rddata),
      .wen(wen), .rdidx(rdidx), .rddata(rddata),
      .fifo_count(fifo_count), .busy(busy)
   );

   always #5 clk = ~clk;

   // Minimal register-file stand-in, committing at the edge after wen.
   always @(posedge clk) begin
      if (resetn && wen) rf[rdidx] <= rddata;
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Monitor: every write the DUT presents must match the next expected one.
   always @(negedge clk) begin
      if (resetn === 1'b1 && wen === 1'b1) begin
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_write: got idx %0d data %h expected no write", rdidx, rddata);
         end else begin
            wr_t e;
            e = exp_q.pop_front();
            chk("wr_idx", 32'(rdidx), 32'(e.idx));
            chk("wr_data", rddata, e.data);
         end
      end
   end

   initial begin
      int n;
      int p;
      resetn = 1'b0; alu_valid = 1'b0; alu_rdidx = '0; alu_rddata = '0;
      lsu_valid = 1'b0; lsu_rdidx = '0; lsu_rddata = '0;

      // Reset values, and alu_ready follows alu_valid while in reset
      #3 alu_valid = 1'b1;
      #1;
      chk("rst_alu_ready", 32'(alu_ready), 32'd1);
      chk("rst_wen", 32'(wen), 32'd0);
      chk("rst_count", 32'(fifo_count), 32'd0);
      chk("rst_lsu_ready", 32'(lsu_ready), 32'd1);
      chk("rst_busy", 32'(busy), 32'd0);
      alu_valid = 1'b0;
      repeat (2) step();
      resetn = 1'b1;
      for (int i = 0; i < 5; i++) begin
         step();
         chk("idle_wen", 32'(wen), 32'd0);
         chk("idle_count", 32'(fifo_count), 32'd0);
         chk("idle_lsu_ready", 32'(lsu_ready), 32'd1);
         chk("idle_busy", 32'(busy), 32'd0);
      end

      // ALU only: 1-cycle latency
      alu_valid = 1'b1; alu_rdidx = 5'd1; alu_rddata = 32'hAABBCCDD;
      #1;
      chk("alu_ready", 32'(alu_ready), 32'd1);
      exp_q.push_back('{5'd1, 32'hAABBCCDD});
      step();
      alu_valid = 1'b0;
      chk("alu_wen", 32'(wen), 32'd1);
      chk("alu_rdidx", 32'(rdidx), 32'd1);
      chk("alu_rddata", rddata, 32'hAABBCCDD);
      step();
      chk("rf_read1", rf[1], 32'hAABBCCDD);

      // LSU only into an empty FIFO: 2-cycle latency
      lsu_valid = 1'b1; lsu_rdidx = 5'd5; lsu_rddata = 32'h12345678;
      exp_q.push_back('{5'd5, 32'h12345678});
      step();
      lsu_valid = 1'b0;
      chk("lsu_c1_count", 32'(fifo_count), 32'd1);
      chk("lsu_c1_wen", 32'(wen), 32'd0);
      step();
      chk("lsu_c2_wen", 32'(wen), 32'd1);
      chk("lsu_c2_rdidx", 32'(rdidx), 32'd5);
      chk("lsu_c2_rddata", rddata, 32'h12345678);
      chk("lsu_c2_count", 32'(fifo_count), 32'd0);
      step();
      chk("lsu_busy_done", 32'(busy), 32'd0);

      // Starvation: ALU held, one push at c0; head forces priority at c4
      n = 0;
      for (int c = 0; c < 7; c++) begin
         alu_valid = 1'b1; alu_rdidx = 5'd2; alu_rddata = 32'hA000_0000 + 32'(n);
         lsu_valid = (c == 0); lsu_rdidx = 5'd20; lsu_rddata = 32'h5555_0001;
         #1;
         chk("starve_alu_ready", 32'(alu_ready), (c == 4) ? 32'd0 : 32'd1);
         if (c == 1) chk("starve_push_visible", 32'(fifo_count), 32'd1);
         if (c == 4) exp_q.push_back('{5'd20, 32'h5555_0001});
         else begin
            exp_q.push_back('{5'd2, 32'hA000_0000 + 32'(n)});
            n++;
         end
         step();
      end
      alu_valid = 1'b0; lsu_valid = 1'b0;
      repeat (3) step();

      // Full FIFO under ALU saturation: 8..11 fill it, 12 stalls until first pop
      n = 0; p = 0;
      for (int c = 0; c < 6; c++) begin
         alu_valid = 1'b1; alu_rdidx = 5'd3; alu_rddata = 32'hB000_0000 + 32'(n);
         lsu_valid = 1'b1; lsu_rdidx = 5'(8 + p); lsu_rddata = 32'hC000_0000 + 32'(8 + p);
         #1;
         chk("full_alu_ready", 32'(alu_ready), (c == 4) ? 32'd0 : 32'd1);
         chk("full_lsu_ready", 32'(lsu_ready), (c == 4) ? 32'd0 : 32'd1);
         if (c == 4) chk("full_count4", 32'(fifo_count), 32'd4);
         if (c == 5) chk("full_count_after_pop", 32'(fifo_count), 32'd3);
         if (c == 4) exp_q.push_back('{5'd8, 32'hC000_0008});
         else begin
            exp_q.push_back('{5'd3, 32'hB000_0000 + 32'(n)});
            n++;
            p++;
         end
         step();
      end
      alu_valid = 1'b0; lsu_valid = 1'b0;
      chk("full_refill_count", 32'(fifo_count), 32'd4);
      for (int k = 9; k <= 12; k++) exp_q.push_back('{5'(k), 32'hC000_0000 + 32'(k)});
      repeat (4) step();
      chk("full_drained", 32'(fifo_count), 32'd0);
      step();

      // x0 destination
      alu_valid = 1'b1; alu_rdidx = 5'd0; alu_rddata = 32'hDEADBEEF;
      #1;
      chk("x0_alu_ready", 32'(alu_ready), 32'd1);
`ifndef CPU4_WB_X0_FILTER_EN
      exp_q.push_back('{5'd0, 32'hDEADBEEF});
`endif
      step();
      alu_valid = 1'b0;
`ifdef CPU4_WB_X0_FILTER_EN
      chk("x0_wen_filtered", 32'(wen), 32'd0);
`else
      chk("x0_wen", 32'(wen), 32'd1);
      chk("x0_rdidx", 32'(rdidx), 32'd0);
`endif
      step();

      // Reset mid-operation with 3 buffered entries and wen high
      for (int c = 0; c < 3; c++) begin
         alu_valid = 1'b1; alu_rdidx = 5'd4; alu_rddata = 32'hE000_0000 + 32'(c);
         lsu_valid = 1'b1; lsu_rdidx = 5'(16 + c); lsu_rddata = 32'hF000_0000 + 32'(c);
         // The c=2 ALU write would appear only after reset hits, so it is not expected
         if (c < 2) exp_q.push_back('{5'd4, 32'hE000_0000 + 32'(c)});
         step();
      end
      chk("pre_rst_wen", 32'(wen), 32'd1);
      chk("pre_rst_count", 32'(fifo_count), 32'd3);
      #1 resetn = 1'b0;
      #1;
      chk("async_rst_wen", 32'(wen), 32'd0);
      chk("async_rst_count", 32'(fifo_count), 32'd0);
      chk("async_rst_busy", 32'(busy), 32'd0);
      chk("async_rst_lsu_ready", 32'(lsu_ready), 32'd1);
      alu_valid = 1'b0; lsu_valid = 1'b0;
      repeat (2) step();
      resetn = 1'b1;
      for (int i = 0; i < 6; i++) begin
         step();
         chk("post_rst_wen", 32'(wen), 32'd0);
         chk("post_rst_count", 32'(fifo_count), 32'd0);
      end

      chk("exp_queue_empty", 32'(exp_q.size()), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
